rca_lsq: RTL and testbench

- Load/store queue that sits between the reconfigurable array's load/store operating units and the data-memory port. It is the responder end of the OU LSQ interface.
- Accepts addr/data/fn3/load/store requests, buffers them in order, and issues them one at a time to memory.
- Performs sub-word lane handling: byte enables, store-data replication, load extraction and extension.
- Returns load results on load_data/load_complete.

---
 rtl/rca_lsq_types.sv | 19 +
 rtl/riscv_types.sv | 10 +
 rtl/taiga_config.sv | 5 +
 rtl/rca_lsq_align.sv | 50 +++++
 rtl/rca_lsq.sv | 183 ++++++++++++++++++
 tb/tb_rca_lsq.sv | 362 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rca_lsq_types.sv
// Types shared by the load/store queue and its lane-alignment helper.
//   lsq_entry_t : one buffered request (byte address, store data, funct3, load flag)
//   lsq_state_t : memory-issue FSM states
package rca_lsq_types;
  import taiga_config::*;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_LOAD = 2'b10
  } lsq_state_t;
endpackage

// File: rtl/riscv_types.sv
// RISC-V encoding constants used by the load/store path.
//   LS_B/LS_H/LS_W : signed byte / half / word access (funct3)
//   LBU/LHU        : zero-extended byte / half loads (funct3)
package riscv_types;
  localparam logic [2:0] LS_B_fn3 = 3'b000;
  localparam logic [2:0] LS_H_fn3 = 3'b001;
  localparam logic [2:0] LS_W_fn3 = 3'b010;
  localparam logic [2:0] LBU_fn3  = 3'b100;
  localparam logic [2:0] LHU_fn3  = 3'b101;
endpackage

// File: rtl/taiga_config.sv
// Core-wide configuration constants shared by the reconfigurable array blocks.
//   XLEN : datapath width in bits (fixed at 32)
package taiga_config;
  localparam int XLEN = 32;
endpackage

// File: rtl/rca_lsq_align.sv
// Combinational sub-word lane handling for the load/store queue.
//   fn3, off   : access size/sign and byte offset (addr[1:0]) of the request
//   st_data    : right-justified store data
//   rdata      : full memory word returned for a load
//   be, wdata  : byte enables and lane-replicated store data
//   ld_result  : extracted and sign/zero-extended load result
// Misaligned halves and words are forced to natural alignment.
module rca_lsq_align
  import taiga_config::*, riscv_types::*;
(
  input  logic [2:0]      fn3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    half_sel  = rdata[{off[1], 4'b0000} +: 16];
    sext      = ~fn3[2];
    be        = 4'b1111;
    wdata     = st_data;
    ld_result = rdata;
    case (fn3)
      LS_B_fn3, LBU_fn3: begin
        be        = 4'b0001 << off;
        wdata     = {(XLEN/8){st_data[7:0]}};
        ld_result = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
      end
      LS_H_fn3, LHU_fn3: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata     = {(XLEN/16){st_data[15:0]}};
        ld_result = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata     = st_data;
        ld_result = rdata;
      end
    endcase
  end

endmodule

// File: rtl/rca_lsq.sv
// Load/store queue between the array's load/store OUs and the data-memory port.
// Requests are buffered in order and issued one at a time (at most one
// outstanding); load results come back on load_data with a one-cycle
// load_complete pulse.
//   clk, rst                      : clock, asynchronous active-high reset
//   addr/data/fn3/load/store      : request fields, qualified by new_request
//   lsq_full                      : no request can be accepted this cycle
//   load_data/load_complete       : extended load result and its valid pulse
//   mem_addr/mem_wdata/mem_be     : word address, replicated data, byte enables
//   mem_rd/mem_wr/mem_req/mem_ack : request qualifiers and handshake
//   mem_rdata/mem_rvalid          : read response
module rca_lsq
  import taiga_config::*, rca_lsq_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);

  lsq_entry_t      entries_q [DEPTH];
  lsq_entry_t      head;
  lsq_entry_t      new_entry;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  lsq_state_t      state_q, state_d;
  logic            enq, deq;

  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            load_complete_q, load_complete_d;

  logic [3:0]      head_be;
  logic [XLEN-1:0] head_wdata;
  logic [XLEN-1:0] ld_result;

  // Full is decoded from the registered count only, so a same-cycle dequeue
  // never frees a slot for that cycle's enqueue.
  assign lsq_full  = (count_q == FULL_COUNT);
  assign enq       = new_request && !lsq_full && (load ^ store);
  assign new_entry = '{addr: addr, data: data, fn3: fn3, load: load};
  assign head      = entries_q[rd_ptr_q];

  // The head stays in the queue until it retires, so the same entry drives
  // both the issue-side lanes and the load-side extraction.
  rca_lsq_align u_align (
    .fn3       (head.fn3),
    .off       (head.addr[1:0]),
    .st_data   (head.data),
    .rdata     (mem_rdata),
    .be        (head_be),
    .wdata     (head_wdata),
    .ld_result (ld_result)
  );

  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    mem_rd_d        = mem_rd_q;
    mem_wr_d        = mem_wr_q;
    mem_req_d       = mem_req_q;
    load_data_d     = load_data_q;
    load_complete_d = 1'b0;
    deq             = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_addr_d  = {head.addr[XLEN-1:2], 2'b00};
          mem_be_d    = head_be;
          mem_wdata_d = head_wdata;
          mem_rd_d    = head.load;
          mem_wr_d    = ~head.load;
          mem_req_d   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_rd_q) begin
            state_d = WAIT_LOAD;
          end else begin
            deq     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          load_data_d     = ld_result;
          load_complete_d = 1'b1;
          deq             = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_req_q       <= 1'b0;
      load_data_q     <= '0;
      load_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      mem_rd_q        <= mem_rd_d;
      mem_wr_q        <= mem_wr_d;
      mem_req_q       <= mem_req_d;
      load_data_q     <= load_data_d;
      load_complete_q <= load_complete_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (enq) entries_q[wr_ptr_q] <= new_entry;
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;
  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_req       = mem_req_q;
  assign load_data     = load_data_q;
  assign load_complete = load_complete_q;

endmodule

// File: tb/tb_rca_lsq.sv
// Self-checking bench for rca_lsq: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// request-queue / byte-memory model of the queue's observable behaviour.
module tb_rca_lsq;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, data = '0, mem_rdata = '0;
  logic [2:0]  fn3 = '0;
  logic        load = 1'b0, store = 1'b0, new_request = 1'b0;
  logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic        lsq_full, load_complete, mem_rd, mem_wr, mem_req;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  rca_lsq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load),
    .store(store), .new_request(new_request), .lsq_full(lsq_full),
    .load_data(load_data), .load_complete(load_complete), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    logic        load;
  } req_t;

  req_t        q[$];
  bit          awaiting = 0;
  logic        lc_exp = 1'b0;
  logic [31:0] ld_exp = '0;
  logic        req_snap = 1'b0;
  logic [7:0]  mem [logic [31:0]];
  int          n_checks = 0, n_fail = 0, stall = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h3;
    return {rd_byte(b + 3), rd_byte(b + 2), rd_byte(b + 1), rd_byte(b)};
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'd0) return 1;
    if (f[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int eoff(input req_t r);
    int nb;
    nb = nbytes(r.fn3);
    if (nb == 1) return int'(r.addr[1:0]);
    if (nb == 2) return r.addr[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input req_t r);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < nbytes(r.fn3); i++) b[eoff(r) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wdata(input req_t r);
    int nb;
    nb = nbytes(r.fn3);
    if (nb == 1) return {24'h0, r.data[7:0]} * 32'h01010101;
    if (nb == 2) return {16'h0, r.data[15:0]} * 32'h00010001;
    return r.data;
  endfunction

  function automatic logic [31:0] exp_load(input req_t r);
    logic [31:0] v, base;
    int nb;
    nb = nbytes(r.fn3);
    base = (r.addr & ~32'h3) + eoff(r);
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd_byte(base + i);
    if (!r.fn3[2] && nb < 4 && v[8*nb-1])
      for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void store_mem(input req_t r);
    logic [31:0] base;
    base = (r.addr & ~32'h3) + eoff(r);
    for (int i = 0; i < nbytes(r.fn3); i++) mem[base + i] = r.data[8*i +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the queue must hold and report after each clock edge.
  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      q.delete();
      awaiting = 0;
      lc_exp   = 1'b0;
      ld_exp   = '0;
    end else begin
      acc    = new_request && (q.size() < DEPTH) && (load ^ store);
      lc_exp = 1'b0;
      if (awaiting) begin
        if (mem_rvalid) begin
          ld_exp   = exp_load(q[0]);
          lc_exp   = 1'b1;
          awaiting = 0;
          void'(q.pop_front());
        end
      end else if (req_snap && mem_ack && q.size() > 0) begin
        if (q[0].load) awaiting = 1;
        else begin
          store_mem(q[0]);
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back('{addr, data, fn3, load});
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    req_snap = mem_req;
    if (rst) begin
      stall = 0;
      check("rst_lsq_full", lsq_full, 0);
      check("rst_load_complete", load_complete, 0);
      check("rst_load_data", load_data, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      check("lsq_full", lsq_full, q.size() == DEPTH);
      check("load_complete", load_complete, lc_exp);
      check("load_data", load_data, ld_exp);
      if (q.size() == 0 || awaiting) begin
        check("mem_req_idle", mem_req, 0);
      end else if (mem_req) begin
        check("mem_addr", mem_addr, q[0].addr & ~32'h3);
        check("mem_be", mem_be, exp_be(q[0]));
        check("mem_rd", mem_rd, q[0].load);
        check("mem_wr", mem_wr, !q[0].load);
        if (!q[0].load) check("mem_wdata", mem_wdata, exp_wdata(q[0]));
      end
      if (q.size() > 0 && !awaiting && !mem_req) begin
        stall++;
        check("issue_stall", stall > 1, 0);
      end else stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic ld, input logic st);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
    tick();
    new_request = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  task automatic respond(input int ack_pct, input int rv_pct);
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    if (awaiting) begin
      if ($urandom_range(99) < rv_pct) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(q[0].addr);
      end
    end else if (mem_req) begin
      if ($urandom_range(99) < ack_pct) mem_ack = 1'b1;
      else if ($urandom_range(99) < 10) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end else if ($urandom_range(99) < 10) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) begin
      respond(60, 50);
      tick();
    end
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] lb_exp;
    tick(); tick();
    check("rst_hold_req", mem_req, 0);
    rst = 1'b0;
    tick();
    check("idle_req", mem_req, 0);
    check("idle_full", lsq_full, 0);

    // Store half, misaligned low bits select the upper lanes.
    do_req(32'h1002, 32'hABCD1234, 3'b001, 1'b0, 1'b1);
    check("sh_lat0", mem_req, 0);
    tick();
    check("sh_req", mem_req, 1);
    check("sh_addr", mem_addr, 32'h1000);
    check("sh_be", mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'h12341234);
    check("sh_wr", mem_wr, 1);
    check("sh_rd", mem_rd, 0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("sh_done", mem_req, 0);
    check("sh_no_lc", load_complete, 0);

    // Seed word 0x2000 = 0x80FFFFFF, then signed and unsigned byte loads.
    do_req(32'h2000, 32'h80FFFFFF, 3'b010, 1'b0, 1'b1);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lb_exp = (k == 0) ? 32'hFFFFFF80 : 32'h00000080;
      do_req(32'h2003, 32'h0, (k == 0) ? 3'b000 : 3'b100, 1'b1, 1'b0);
      tick();
      check("lb_req", mem_req, 1);
      check("lb_rd", mem_rd, 1);
      check("lb_addr", mem_addr, 32'h2000);
      check("lb_be", mem_be, 4'b1000);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      tick();
      check("lb_wait", load_complete, 0);
      mem_rdata = 32'h80FFFFFF; mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
      check("lb_lc", load_complete, 1);
      check("lb_data", load_data, lb_exp);
      check("lb_model_pin", ld_exp, lb_exp);
      tick();
      check("lb_lc_pulse", load_complete, 0);
      check("lb_hold", load_data, lb_exp);
    end

    // Full queue with ack held low; the fifth request waits for a free slot.
    for (int i = 0; i < 4; i++) do_req(32'h400 + 32'(4 * i), $urandom, 3'b010, 1'b0, 1'b1);
    check("full_set", lsq_full, 1);
    addr = 32'h500; data = 32'h55; fn3 = 3'b010; store = 1'b1; new_request = 1'b1;
    tick();
    check("full_ignore", lsq_full, 1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("full_freed", lsq_full, 0);
    tick();
    new_request = 1'b0; store = 1'b0;
    check("full_again", lsq_full, 1);
    drain();

    // Program order: write reaches memory before the dependent read.
    do_req(32'h3000, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1);
    do_req(32'h3000, 32'h0, 3'b010, 1'b1, 1'b0);
    check("ord_wr_first", mem_wr, 1);
    check("ord_wr_addr", mem_addr, 32'h3000);
    check("ord_wr_data", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    tick();
    check("ord_rd_second", mem_rd, 1);
    check("ord_rd_req", mem_req, 1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    mem_rdata = mem_word(32'h3000); mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    check("ord_lc", load_complete, 1);
    check("ord_data", load_data, 32'hDEADBEEF);

    // Invalid requests (both and neither) are dropped.
    do_req(32'h4000, 32'h1, 3'b010, 1'b1, 1'b1);
    do_req(32'h4000, 32'h1, 3'b010, 1'b0, 1'b0);
    check("inv_full", lsq_full, 0);
    check("inv_req", mem_req, 0);
    tick();
    check("inv_req2", mem_req, 0);

    // Reset with a request pending drops mem_req without a clock edge.
    do_req(32'h600, 32'h77, 3'b010, 1'b0, 1'b1);
    tick();
    check("rq_pending", mem_req, 1);
    rst = 1'b1;
    #1;
    check("rq_async_drop", mem_req, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rq_after_req", mem_req, 0);
    check("rq_after_full", lsq_full, 0);

    // Reset during WAIT_LOAD; a late response must be ignored.
    do_req(32'h2000, 32'h0, 3'b010, 1'b1, 1'b0);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    mem_rdata = 32'h12345678; mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    check("rw_no_lc", load_complete, 0);
    check("rw_data", load_data, 0);
    check("rw_full", lsq_full, 0);
    check("rw_req", mem_req, 0);
    tick();
    check("rw_req2", mem_req, 0);

    // Randomized traffic in a small address window so loads hit earlier stores.
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind = int'($urandom_range(9));
      new_request = ($urandom_range(1) == 1);
      addr  = 32'h100 + $urandom_range(15);
      data  = $urandom;
      load  = (kind == 0) || (kind >= 6);
      store = (kind == 0) || (kind >= 2 && kind < 6);
      if (load && !store) begin
        case ($urandom_range(4))
          0: fn3 = 3'b000;
          1: fn3 = 3'b001;
          2: fn3 = 3'b010;
          3: fn3 = 3'b100;
          default: fn3 = 3'b101;
        endcase
      end else fn3 = 3'($urandom_range(2));
      respond(40, 40);
      if ($urandom_range(999) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      tick();
    end
    new_request = 1'b0; load = 1'b0; store = 1'b0;
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
